// File: rtl/mod_n_down_counter_pkg.sv
// Shared definitions for the modulo-N down counter: FSM encoding and the load clamp.
package mod_n_down_counter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int CLAMP_W = 32;

  // Unsigned saturate of a requested load value to the top of the count range.
  function automatic logic [CLAMP_W-1:0] clamp_val(input logic [CLAMP_W-1:0] val,
                                                   input logic [CLAMP_W-1:0] lim);
    logic [CLAMP_W-1:0] res;
    if (val > lim) begin
      res = lim;
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/mod_n_down_counter_if.sv
// Control/status bundle of the modulo-N down counter; clk and rst stay outside.
interface mod_n_down_counter_if #(
  parameter int WIDTH = 4
);

  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             one_shot;
  logic [WIDTH-1:0] d_out;
  logic             zero;
  logic             borrow;
  logic             done;
  logic             busy;

  modport master (
    output en, load, load_val, start, one_shot,
    input  d_out, zero, borrow, done, busy
  );

  modport slave (
    input  en, load, load_val, start, one_shot,
    output d_out, zero, borrow, done, busy
  );

endinterface

// File: rtl/mod_n_down_counter_down_count_stage.sv
// One bit of the down counter: T-type flop with synchronous load and borrow-chain output.
module down_count_stage (
  input  logic clk,
  input  logic rst,
  input  logic en_chain,
  input  logic load_en,
  input  logic load_bit,
  output logic q,
  output logic chain_out
);

  logic q_r;

  // Load beats toggle; toggle only when every lower bit is already 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= 1'b0;
    end else if (load_en) begin
      q_r <= load_bit;
    end else if (en_chain) begin
      q_r <= ~q_r;
    end else begin
      q_r <= q_r;
    end
  end

  assign q         = q_r;
  assign chain_out = en_chain & ~q_r;

endmodule

// File: rtl/mod_n_down_counter.sv
// Modulo-N down counter with load, pause, wrap borrow pulse and one-shot countdown.
module mod_n_down_counter
  import mod_n_down_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  mod_n_down_counter_if.slave  bus
);

  if (WIDTH < 1 || WIDTH > 31) begin : g_bad_width
    $error("mod_n_down_counter: WIDTH must be 1..31");
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("mod_n_down_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [1:0]       state_r;
  logic [1:0]       next_state_s;
  logic             borrow_r;
  logic             done_r;
  logic             busy_r;
  logic             borrow_nxt_s;
  logic             ld_s;
  logic [WIDTH-1:0] ld_val_s;
  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH:0]   chain_s;

  // The chain runs past the MSB, so its last tap marks an enabled edge at count 0.
  assign chain_s[0] = (state_r == ST_RUN) & bus.en & ~bus.load;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    down_count_stage u_stage (
      .clk       (clk),
      .rst       (rst),
      .en_chain  (chain_s[i]),
      .load_en   (ld_s),
      .load_bit  (ld_val_s[i]),
      .q         (cnt_r[i]),
      .chain_out (chain_s[i+1])
    );
  end

  // Next-state, load muxing and borrow decision.
  always_comb begin
    next_state_s = state_r;
    ld_s         = 1'b0;
    ld_val_s     = cnt_r;
    borrow_nxt_s = 1'b0;
    if (bus.load) begin
      ld_s         = 1'b1;
      ld_val_s     = WIDTH'(clamp_val(CLAMP_W'(bus.load_val), CLAMP_W'(MAX_VAL)));
      next_state_s = ST_RUN;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            next_state_s = ST_RUN;
          end else begin
            next_state_s = ST_IDLE;
          end
        end
        ST_DONE: begin
          if (bus.start) begin
            next_state_s = ST_RUN;
            ld_s         = 1'b1;
            ld_val_s     = MAX_VAL;
          end else begin
            next_state_s = ST_DONE;
          end
        end
        ST_RUN: begin
          if (chain_s[WIDTH]) begin
            // Override the all-bits toggle the chain would otherwise apply at zero.
            ld_s = 1'b1;
            if (bus.one_shot) begin
              ld_val_s     = {WIDTH{1'b0}};
              next_state_s = ST_DONE;
            end else begin
              ld_val_s     = MAX_VAL;
              borrow_nxt_s = 1'b1;
            end
          end else begin
            next_state_s = ST_RUN;
          end
        end
        default: begin
          next_state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      borrow_r <= 1'b0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      borrow_r <= borrow_nxt_s;
      done_r   <= (next_state_s == ST_DONE);
      busy_r   <= (next_state_s == ST_RUN);
    end
  end

  assign bus.d_out  = cnt_r;
  assign bus.zero   = (cnt_r == {WIDTH{1'b0}});
  assign bus.borrow = borrow_r;
  assign bus.done   = done_r;
  assign bus.busy   = busy_r;

endmodule

// File: tb/tb_mod_n_down_counter.sv
// Directed-vector bench for mod_n_down_counter (MODULUS=10 and MODULUS=16 instances).
module tb_mod_n_down_counter;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  mod_n_down_counter_if #(.WIDTH(4)) bus10 ();
  mod_n_down_counter_if #(.WIDTH(4)) bus16 ();

  mod_n_down_counter #(.WIDTH(4), .MODULUS(10)) dut10 (.clk(clk), .rst(rst), .bus(bus10));
  mod_n_down_counter #(.WIDTH(4), .MODULUS(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  // Observation word: {d_out, zero, borrow, done, busy}.
  wire [7:0] obs10 = {bus10.d_out, bus10.zero, bus10.borrow, bus10.done, bus10.busy};
  wire [7:0] obs16 = {bus16.d_out, bus16.zero, bus16.borrow, bus16.done, bus16.busy};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus10.en = 1'b0; bus10.load = 1'b0; bus10.load_val = 4'd0; bus10.start = 1'b0; bus10.one_shot = 1'b0;
    bus16.en = 1'b0; bus16.load = 1'b0; bus16.load_val = 4'd0; bus16.start = 1'b0; bus16.one_shot = 1'b0;
    #12;
    if (obs10 !== 8'h08) begin $display("FAIL reset10 got=%h exp=%h", obs10, 8'h08); miscompares++; end
    vectors++;
    if (obs16 !== 8'h08) begin $display("FAIL reset16 got=%h exp=%h", obs16, 8'h08); miscompares++; end
    vectors++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    logic [7:0] exp_tab [6] = '{8'h31, 8'h21, 8'h11, 8'h09, 8'h95, 8'h81};
    bus10.load = 1'b1; bus10.load_val = 4'd3; bus10.one_shot = 1'b0; bus10.en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      bus10.load = 1'b0;
      if (obs10 !== exp_tab[i]) begin $display("FAIL wrap[%0d] got=%h exp=%h", i, obs10, exp_tab[i]); miscompares++; end
      vectors++;
    end
  endtask

  task automatic test_one_shot();
    logic [7:0] exp_tab [9] = '{8'h21, 8'h11, 8'h09, 8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h0A};
    bus10.load = 1'b1; bus10.load_val = 4'd2; bus10.one_shot = 1'b1; bus10.en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      bus10.load = 1'b0;
      if (obs10 !== exp_tab[i]) begin $display("FAIL one_shot[%0d] got=%h exp=%h", i, obs10, exp_tab[i]); miscompares++; end
      vectors++;
    end
    bus10.start = 1'b1;
    tick();
    bus10.start = 1'b0;
    if (obs10 !== 8'h91) begin $display("FAIL restart got=%h exp=%h", obs10, 8'h91); miscompares++; end
    vectors++;
  endtask

  task automatic test_load_zero_one_shot();
    logic [7:0] exp_tab [2] = '{8'h09, 8'h0A};
    bus10.load = 1'b1; bus10.load_val = 4'd0; bus10.one_shot = 1'b1; bus10.en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      bus10.load = 1'b0;
      if (obs10 !== exp_tab[i]) begin $display("FAIL load_zero[%0d] got=%h exp=%h", i, obs10, exp_tab[i]); miscompares++; end
      vectors++;
    end
  endtask

  task automatic test_clamp();
    logic [7:0] exp_tab [3] = '{8'h09, 8'hF5, 8'hE1};
    bus10.load = 1'b1; bus10.load_val = 4'd13; bus10.en = 1'b0;
    tick();
    bus10.load = 1'b0;
    if (obs10 !== 8'h91) begin $display("FAIL clamp13 got=%h exp=%h", obs10, 8'h91); miscompares++; end
    vectors++;
    bus16.load = 1'b1; bus16.load_val = 4'd15; bus16.en = 1'b0;
    tick();
    if (obs16 !== 8'hF1) begin $display("FAIL clamp15_m16 got=%h exp=%h", obs16, 8'hF1); miscompares++; end
    vectors++;
    // Full-range wrap: 0 -> 15 with borrow on the MODULUS=16 instance.
    bus16.load_val = 4'd0; bus16.en = 1'b1; bus16.one_shot = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus16.load = 1'b0;
      if (obs16 !== exp_tab[i]) begin $display("FAIL wrap16[%0d] got=%h exp=%h", i, obs16, exp_tab[i]); miscompares++; end
      vectors++;
    end
    bus16.en = 1'b0;
  endtask

  task automatic test_load_priority();
    logic [7:0] exp_tab [3] = '{8'h51, 8'h71, 8'h61};
    bus10.load = 1'b1; bus10.load_val = 4'd5; bus10.en = 1'b1; bus10.one_shot = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus10.load     = (i == 0);
      bus10.load_val = 4'd7;
      if (obs10 !== exp_tab[i]) begin $display("FAIL load_prio[%0d] got=%h exp=%h", i, obs10, exp_tab[i]); miscompares++; end
      vectors++;
    end
  endtask

  task automatic test_pause();
    logic [7:0] exp_tab [6] = '{8'h41, 8'h41, 8'h41, 8'h41, 8'h31, 8'h21};
    bus10.load = 1'b1; bus10.load_val = 4'd4; bus10.en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      bus10.load  = 1'b0;
      bus10.en    = (i >= 3);
      bus10.start = (i == 4);
      if (obs10 !== exp_tab[i]) begin $display("FAIL pause[%0d] got=%h exp=%h", i, obs10, exp_tab[i]); miscompares++; end
      vectors++;
    end
    bus10.start = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_tab [4] = '{8'h91, 8'h81, 8'h71, 8'h61};
    bus10.load = 1'b1; bus10.load_val = 4'd9; bus10.en = 1'b1; bus10.one_shot = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      bus10.load = 1'b0;
      if (obs10 !== exp_tab[i]) begin $display("FAIL pre_reset[%0d] got=%h exp=%h", i, obs10, exp_tab[i]); miscompares++; end
      vectors++;
    end
    #2 rst = 1'b1;
    #1;
    if (obs10 !== 8'h08) begin $display("FAIL async_reset got=%h exp=%h", obs10, 8'h08); miscompares++; end
    vectors++;
    #2 rst = 1'b0;
    tick();
    if (obs10 !== 8'h08) begin $display("FAIL post_reset_idle got=%h exp=%h", obs10, 8'h08); miscompares++; end
    vectors++;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_wrap();
    test_one_shot();
    test_load_zero_one_shot();
    test_clamp();
    test_load_priority();
    test_pause();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
